// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - stretched core reset plus DEPTH-entry execution trace FIFO (optional ring mode: TRACE_WRAP_EN)
module cpu_trace_buffer #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int RST_HOLD = 4,
    parameter int MODE     = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic                     core_reset,
    input  logic [DATA_W-1:0]        pc,
    input  logic [DATA_W-1:0]        instr,
    input  logic                     mem_write,
    input  logic [DATA_W-1:0]        data_adr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [3:0]               alu_flags,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_pc,
    output logic [DATA_W-1:0]        rd_word,
    output logic [DATA_W-1:0]        rd_aux,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [1:0]               state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

`ifdef TRACE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_IDLE    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              cur_state;
    state_t              nxt_state;
    logic [HW-1:0]       hold_cnt;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [DATA_W-1:0]   last_pc;

    logic [DATA_W-1:0]   mem_pc   [DEPTH];
    logic [DATA_W-1:0]   mem_word [DEPTH];
    logic [DATA_W-1:0]   mem_aux  [DEPTH];

    logic [DATA_W-1:0]   tap_word;
    logic [DATA_W-1:0]   tap_aux;
    logic                sample;
    logic                pop;
    logic                wr_en;
    logic                overwrite;
    logic                ovf_event;
    logic                rearm;

    // Entry payload depends on trace flavour: fetch logs instr/flags, store logs data/address
    assign tap_word = (MODE == 0) ? instr : write_data;
    assign tap_aux  = (MODE == 0) ? {{(DATA_W-4){1'b0}}, alu_flags} : data_adr;

    assign full       = (count == CW'(DEPTH));
    assign core_reset = (cur_state == S_HOLD);
    assign state      = cur_state;

    // Capture qualification and FIFO control; a pop in the same cycle frees the slot for a write when full
    always_comb begin
        sample    = 1'b0;
        if (cur_state == S_CAPTURE) begin
            sample = (MODE == 0) ? (pc != last_pc) : mem_write;
        end
        pop       = (cur_state != S_HOLD) && rd_en && (count != '0);
        ovf_event = sample && full && !pop;
        overwrite = ovf_event && WRAP;
        wr_en     = sample && (!full || pop || WRAP);
        rearm     = (cur_state == S_DONE) && arm;
    end

    // Next-state logic; a dropped sample in stop-on-full mode ends capture on the same edge
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_HOLD: begin
                if (hold_cnt == HW'(RST_HOLD - 1)) begin
                    nxt_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (arm) begin
                    nxt_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (stop || (ovf_event && !WRAP)) begin
                    nxt_state = S_DONE;
                end
            end
            S_DONE: begin
                if (arm) begin
                    nxt_state = S_CAPTURE;
                end
            end
            default: nxt_state = S_HOLD;
        endcase
    end

    // State register and reset-stretch counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur_state <= S_HOLD;
            hold_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Trace storage; contents need no reset since count gates every read
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_pc[wr_ptr]   <= pc;
            mem_word[wr_ptr] <= tap_word;
            mem_aux[wr_ptr]  <= tap_aux;
        end
    end

    // Pointers, occupancy, sticky overflow and fetch-trace pc history
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            last_pc  <= '1;
        end else if (rearm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            last_pc  <= '1;
        end else begin
            if (sample && (MODE == 0)) begin
                last_pc <= pc;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop && !overwrite) begin
                count <= count + 1'b1;
            end else if (pop && !wr_en) begin
                count <= count - 1'b1;
            end
            if (ovf_event) begin
                overflow <= 1'b1;
            end
        end
    end

    // Read port: popped entry appears one cycle after rd_en and holds until the next pop
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_valid <= 1'b0;
            rd_pc    <= '0;
            rd_word  <= '0;
            rd_aux   <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_pc   <= mem_pc[rd_ptr];
                rd_word <= mem_word[rd_ptr];
                rd_aux  <= mem_aux[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - bench for cpu_trace_buffer in fetch and store trace modes against a queue model
module tb_cpu_trace_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

`ifdef TRACE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] pc, instr, data_adr, write_data;
    logic          mem_write, arm, stop, rd_en;
    logic [3:0]    alu_flags;

    logic          core_reset0, rd_valid0, full0, overflow0;
    logic [DW-1:0] rd_pc0, rd_word0, rd_aux0;
    logic [2:0]    count0;
    logic [1:0]    state0;
    logic          core_reset1, rd_valid1, full1, overflow1;
    logic [DW-1:0] rd_pc1, rd_word1, rd_aux1;
    logic [2:0]    count1;
    logic [1:0]    state1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .RST_HOLD(HOLD), .MODE(0)) u0 (
        .CLK(CLK), .RESET(RESET), .core_reset(core_reset0), .pc(pc), .instr(instr),
        .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data), .alu_flags(alu_flags),
        .arm(arm), .stop(stop), .rd_en(rd_en), .rd_valid(rd_valid0), .rd_pc(rd_pc0),
        .rd_word(rd_word0), .rd_aux(rd_aux0), .count(count0), .full(full0),
        .overflow(overflow0), .state(state0)
    );

    cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .RST_HOLD(HOLD), .MODE(1)) u1 (
        .CLK(CLK), .RESET(RESET), .core_reset(core_reset1), .pc(pc), .instr(instr),
        .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data), .alu_flags(alu_flags),
        .arm(arm), .stop(stop), .rd_en(rd_en), .rd_valid(rd_valid1), .rd_pc(rd_pc1),
        .rd_word(rd_word1), .rd_aux(rd_aux1), .count(count1), .full(full1),
        .overflow(overflow1), .state(state1)
    );

    // Reference model: phase, remaining entries as a queue, and the read-port view
    logic [3*DW-1:0] q0[$];
    logic [3*DW-1:0] q1[$];
    int              m_state[2] = '{0, 0};
    int              m_hold[2]  = '{0, 0};
    logic            m_ovf[2]   = '{1'b0, 1'b0};
    logic [DW-1:0]   m_last[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic            m_rdv[2]   = '{1'b0, 1'b0};
    logic [DW-1:0]   m_rp[2]    = '{0, 0};
    logic [DW-1:0]   m_rw[2]    = '{0, 0};
    logic [DW-1:0]   m_ra[2]    = '{0, 0};
    int              m_cnt[2]   = '{0, 0};

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance model instance i by one clock edge using the inputs that edge will sample
    task automatic model_step(input int i);
        logic [3*DW-1:0] q[$];
        logic [3*DW-1:0] e;
        logic            take, qual;
        int              nst;
        if (i == 0) q = q0; else q = q1;
        if (RESET) begin
            q.delete();
            m_state[i] = 0; m_hold[i] = 0; m_ovf[i] = 1'b0; m_last[i] = '1;
            m_rdv[i] = 1'b0; m_rp[i] = '0; m_rw[i] = '0; m_ra[i] = '0;
        end else begin
            take = (m_state[i] != 0) && rd_en && (q.size() > 0);
            m_rdv[i] = take;
            if (take) begin
                {m_rp[i], m_rw[i], m_ra[i]} = q[0];
                void'(q.pop_front());
            end
            nst = m_state[i];
            case (m_state[i])
                0: begin
                    m_hold[i]++;
                    if (m_hold[i] == HOLD) nst = 1;
                end
                1: if (arm) nst = 2;
                2: begin
                    qual = (i == 0) ? (pc != m_last[i]) : mem_write;
                    e = (i == 0) ? {pc, instr, 28'd0, alu_flags} : {pc, write_data, data_adr};
                    if (qual) begin
                        if (i == 0) m_last[i] = pc;
                        if (q.size() < DEPTH) begin
                            q.push_back(e);
                        end else begin
                            m_ovf[i] = 1'b1;
                            if (WRAP) begin
                                void'(q.pop_front());
                                q.push_back(e);
                            end else begin
                                nst = 3;
                            end
                        end
                    end
                    if (stop) nst = 3;
                end
                default: begin
                    if (arm) begin
                        q.delete();
                        m_ovf[i] = 1'b0;
                        m_last[i] = '1;
                        nst = 2;
                    end
                end
            endcase
            m_state[i] = nst;
        end
        m_cnt[i] = q.size();
        if (i == 0) q0 = q; else q1 = q;
    endtask

    task automatic cmp_inst(input int i, input logic cr, input logic [1:0] st, input logic [2:0] cnt,
                            input logic fl, input logic ov, input logic rv,
                            input logic [DW-1:0] rp, input logic [DW-1:0] rw, input logic [DW-1:0] ra);
        check($sformatf("u%0d.core_reset", i), DW'(cr), DW'(m_state[i] == 0));
        check($sformatf("u%0d.state", i), DW'(st), DW'(m_state[i]));
        check($sformatf("u%0d.count", i), DW'(cnt), DW'(m_cnt[i]));
        check($sformatf("u%0d.full", i), DW'(fl), DW'(m_cnt[i] == DEPTH));
        check($sformatf("u%0d.overflow", i), DW'(ov), DW'(m_ovf[i]));
        check($sformatf("u%0d.rd_valid", i), DW'(rv), DW'(m_rdv[i]));
        check($sformatf("u%0d.rd_pc", i), rp, m_rp[i]);
        check($sformatf("u%0d.rd_word", i), rw, m_rw[i]);
        check($sformatf("u%0d.rd_aux", i), ra, m_ra[i]);
    endtask

    // Mid-cycle: compare both DUTs with the model, then step the model for the coming edge
    always @(negedge CLK) begin
        cmp_inst(0, core_reset0, state0, count0, full0, overflow0, rd_valid0, rd_pc0, rd_word0, rd_aux0);
        cmp_inst(1, core_reset1, state1, count1, full1, overflow1, rd_valid1, rd_pc1, rd_word1, rd_aux1);
        model_step(0);
        model_step(1);
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [DW-1:0] instr_of(input logic [DW-1:0] p);
        return 32'hE1A0_0000 | p;
    endfunction

    logic [DW-1:0] exp_pc[4];

    initial begin
        RESET = 1'b1; arm = 0; stop = 0; rd_en = 0; pc = 0; instr = 0;
        mem_write = 0; data_adr = 0; write_data = 0; alu_flags = 0;
        repeat (3) tick();
        RESET = 1'b0;

        // Reset stretch: high for exactly HOLD cycles after RESET falls
        check("hold_cr_first", DW'(core_reset0), 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("hold_cr", DW'(core_reset0), 1);
            check("hold_state", DW'(state0), 0);
        end
        tick();
        check("release_cr", DW'(core_reset0), 0);
        check("idle_state", DW'(state0), 1);
        check("idle_count", DW'(count0), 0);
        check("idle_rdv", DW'(rd_valid0), 0);

        // Fetch trace with a stalled pc
        arm = 1; tick(); arm = 0;
        check("cap_state", DW'(state0), 2);
        pc = 0; instr = instr_of(0); alu_flags = 4'h1; tick();
        pc = 4; instr = instr_of(4); alu_flags = 4'h2; tick();
        tick();
        pc = 8; instr = instr_of(8); alu_flags = 4'h4; tick();
        stop = 1; tick(); stop = 0;
        check("fetch_count", DW'(count0), 3);
        check("fetch_done", DW'(state0), 3);
        rd_en = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fetch_rdv", DW'(rd_valid0), 1);
            check("fetch_pc", rd_pc0, DW'(4 * k));
            check("fetch_instr", rd_word0, instr_of(DW'(4 * k)));
        end
        tick();
        check("fetch_empty_rdv", DW'(rd_valid0), 0);
        rd_en = 0;

        // Store trace
        arm = 1; tick(); arm = 0;
        mem_write = 1; data_adr = 32'h100; write_data = 32'h11; tick();
        mem_write = 0; tick();
        mem_write = 1; data_adr = 32'h104; write_data = 32'h22; tick();
        mem_write = 0; stop = 1; tick(); stop = 0;
        check("store_count", DW'(count1), 2);
        rd_en = 1;
        tick();
        check("store_rdv0", DW'(rd_valid1), 1);
        check("store_aux0", rd_aux1, 32'h100);
        check("store_word0", rd_word1, 32'h11);
        tick();
        check("store_aux1", rd_aux1, 32'h104);
        check("store_word1", rd_word1, 32'h22);
        tick();
        check("store_empty_rdv", DW'(rd_valid1), 0);
        tick();
        check("store_empty_rdv2", DW'(rd_valid1), 0);
        check("store_hold_aux", rd_aux1, 32'h104);
        rd_en = 0;

        // Six distinct pcs into a four-entry buffer
        arm = 1; tick(); arm = 0;
        for (int k = 0; k < 6; k++) begin
            pc = DW'(4 * k); instr = instr_of(pc); tick();
            if (k == 3) begin
                check("ovf_full", DW'(full0), 1);
                check("ovf_not_yet", DW'(overflow0), 0);
            end
            if (k == 4) begin
                check("ovf_set", DW'(overflow0), 1);
                check("ovf_state", DW'(state0), WRAP ? 2 : 3);
                check("ovf_count", DW'(count0), 4);
            end
        end
        stop = 1; tick(); stop = 0;
        check("ovf_stop_state", DW'(state0), 3);
        if (WRAP) exp_pc = '{32'd8, 32'd12, 32'd16, 32'd20};
        else      exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12};
        rd_en = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ovf_entry_pc", rd_pc0, exp_pc[k]);
        end
        rd_en = 0;

        // Full buffer with simultaneous pop and write, then reset mid-capture
        arm = 1; tick(); arm = 0;
        for (int k = 0; k < 4; k++) begin
            pc = 32'h100 + DW'(4 * k); instr = instr_of(pc); tick();
        end
        check("pw_full", DW'(count0), 4);
        pc = 32'h110; instr = instr_of(pc); rd_en = 1; tick(); rd_en = 0;
        check("pw_count", DW'(count0), 4);
        check("pw_ovf", DW'(overflow0), 0);
        check("pw_rdpc", rd_pc0, 32'h100);
        check("pw_state", DW'(state0), 2);
        RESET = 1; tick(); RESET = 0;
        check("rst_count", DW'(count0), 0);
        check("rst_cr", DW'(core_reset0), 1);
        check("rst_state", DW'(state0), 0);

        // Randomized traffic checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            RESET      = ($urandom_range(0, 499) == 0);
            arm        = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            rd_en      = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0) pc = DW'($urandom_range(0, 7)) << 2;
            instr      = $urandom;
            alu_flags  = 4'($urandom_range(0, 15));
            mem_write  = ($urandom_range(0, 2) == 0);
            data_adr   = $urandom;
            write_data = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
